ps2_key_cmd: RTL and testbench

//  Downstream consumer of the PS/2 scan-code receiver. Takes its 10-bit {expand,break,code} word
//  and its active-low one-cycle ready strobe, and translates maze-control key presses into 3-bit

---
 rtl/ps2_key_cmd.sv | 179 +++++++++++++++++
 tb/tb_ps2_key_cmd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_cmd.sv
// ps2_key_cmd: turns PS/2 scan-code events into queued maze-game commands.
// A two-stage pipeline registers the receiver strobe and code, then decodes the
// key, updates the key-held bitmap and writes the command FIFO that the CPU pops.
module ps2_key_cmd #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [9:0]    i_ps2_code,
    input  logic          i_ps2_ready_n,
    input  logic          i_cmd_pop,
    output logic [2:0]    o_cmd_data,
    output logic          o_cmd_valid,
    output logic [AW:0]   o_cmd_count,
    output logic [9:0]    o_key_held,
    output logic          o_overflow,
    input  logic          i_ovf_clr
);

    // Game command encoding; CMD_RSVD is never produced by the decoder.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_ENTER = 3'd5,
        CMD_ESC   = 3'd6,
        CMD_RSVD  = 3'd7
    } cmd_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Stage 1 state: registered strobe (for edge detect) and captured event.
    logic          r_rdy_q;
    logic          r_vld_q;
    logic [9:0]    r_code_q;

    // Stage 2 / FIFO state.
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [9:0]    r_key_held;
    logic          r_overflow;

    // Decode and FIFO control nets.
    logic          w_new;
    logic          w_hit;
    logic [9:0]    w_mask;
    cmd_t          w_cmd;
    logic          w_is_break;
    logic          w_was_held;
    logic          w_push;
    logic          w_nonempty;
    logic          w_full;
    logic          w_pop_eff;
    logic          w_wr;
    logic          w_drop;

    // A falling edge of the receiver strobe is one event, however long it stays low.
    assign w_new = r_rdy_q & ~i_ps2_ready_n;

    // Stage 1: register the strobe level and capture the code for one cycle of work.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdy_q  <= 1'b1;
            r_vld_q  <= 1'b0;
            r_code_q <= '0;
        end else begin
            r_rdy_q <= i_ps2_ready_n;
            r_vld_q <= w_new;
            if (w_new) begin
                r_code_q <= i_ps2_code;
            end
        end
    end

    // Key map lookup: expand flag and scan byte must both match; break bit is ignored here.
    always_comb begin
        w_hit  = 1'b0;
        w_mask = '0;
        w_cmd  = CMD_NONE;
        case ({r_code_q[9], r_code_q[7:0]})
            9'h175: begin w_hit = 1'b1; w_mask = 10'b00_0000_0001; w_cmd = CMD_UP;    end
            9'h172: begin w_hit = 1'b1; w_mask = 10'b00_0000_0010; w_cmd = CMD_DOWN;  end
            9'h16B: begin w_hit = 1'b1; w_mask = 10'b00_0000_0100; w_cmd = CMD_LEFT;  end
            9'h174: begin w_hit = 1'b1; w_mask = 10'b00_0000_1000; w_cmd = CMD_RIGHT; end
            9'h01D: begin w_hit = 1'b1; w_mask = 10'b00_0001_0000; w_cmd = CMD_UP;    end
            9'h01B: begin w_hit = 1'b1; w_mask = 10'b00_0010_0000; w_cmd = CMD_DOWN;  end
            9'h01C: begin w_hit = 1'b1; w_mask = 10'b00_0100_0000; w_cmd = CMD_LEFT;  end
            9'h023: begin w_hit = 1'b1; w_mask = 10'b00_1000_0000; w_cmd = CMD_RIGHT; end
            9'h05A: begin w_hit = 1'b1; w_mask = 10'b01_0000_0000; w_cmd = CMD_ENTER; end
            9'h076: begin w_hit = 1'b1; w_mask = 10'b10_0000_0000; w_cmd = CMD_ESC;   end
            default: begin
                w_hit  = 1'b0;
                w_mask = '0;
                w_cmd  = CMD_NONE;
            end
        endcase
    end

    assign w_is_break = r_code_q[8];
    assign w_was_held = |(r_key_held & w_mask);

    // Only the first make of a held key pushes, unless typematic repeats are wanted.
    assign w_push = r_vld_q & w_hit & ~w_is_break & (~w_was_held | REPEAT_EN);

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == FULL_CNT);
    // A pop against an empty FIFO is ignored, so a same-cycle push on empty is push-only.
    assign w_pop_eff  = i_cmd_pop & w_nonempty;
    // When full, a push only lands if the head is leaving in the same cycle.
    assign w_wr       = w_push & (~w_full | w_pop_eff);
    assign w_drop     = w_push & w_full & ~w_pop_eff;

    // Key-held bitmap follows every mapped make/break, even when the command is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key_held <= '0;
        end else if (r_vld_q && w_hit) begin
            if (w_is_break) begin
                r_key_held <= r_key_held & ~w_mask;
            end else begin
                r_key_held <= r_key_held | w_mask;
            end
        end
    end

    // FIFO storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wr_ptr] <= w_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop_eff})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_cmd_data  = w_nonempty ? r_mem[r_rd_ptr] : 3'd0;
    assign o_cmd_valid = w_nonempty;
    assign o_cmd_count = r_count;
    assign o_key_held  = r_key_held;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_cmd.sv
// tb_ps2_key_cmd: directed bench for ps2_key_cmd with a queue-based command scoreboard.
// A second instance with typematic repeat enabled shares the same stimulus.
module tb_ps2_key_cmd;

    logic        clk;
    logic        rst;
    logic [9:0]  ps2Code;
    logic        ps2ReadyN;
    logic        cmdPop;
    logic        ovfClr;

    logic [2:0]  cmdData;
    logic        cmdValid;
    logic [3:0]  cmdCount;
    logic [9:0]  keyHeld;
    logic        overflow;

    logic [2:0]  cmdDataRep;
    logic        cmdValidRep;
    logic [3:0]  cmdCountRep;
    logic [9:0]  keyHeldRep;
    logic        overflowRep;

    int          vectors     = 0;
    int          miscompares = 0;

    // Scoreboard and reference state for the non-repeat instance.
    logic [2:0]  expQ[$];
    logic [9:0]  heldModel;
    logic        ovfModel;
    int          cmdOf[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6};
    logic [9:0]  fillKeys[9] = '{10'h272, 10'h26B, 10'h274, 10'h01D, 10'h01B,
                                 10'h01C, 10'h023, 10'h05A, 10'h076};

    ps2_key_cmd #(.DEPTH(8), .AW(3), .REPEAT_EN(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_ps2_code(ps2Code), .i_ps2_ready_n(ps2ReadyN),
        .i_cmd_pop(cmdPop), .o_cmd_data(cmdData), .o_cmd_valid(cmdValid),
        .o_cmd_count(cmdCount), .o_key_held(keyHeld), .o_overflow(overflow),
        .i_ovf_clr(ovfClr)
    );

    ps2_key_cmd #(.DEPTH(8), .AW(3), .REPEAT_EN(1'b1)) dutRep (
        .i_clk(clk), .i_rst(rst), .i_ps2_code(ps2Code), .i_ps2_ready_n(ps2ReadyN),
        .i_cmd_pop(cmdPop), .o_cmd_data(cmdDataRep), .o_cmd_valid(cmdValidRep),
        .o_cmd_count(cmdCountRep), .o_key_held(keyHeldRep), .o_overflow(overflowRep),
        .i_ovf_clr(ovfClr)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key table: index of a mapped key or -1.
    function automatic int lookupKey(input logic [9:0] code);
        case ({code[9], code[7:0]})
            9'h175: return 0;
            9'h172: return 1;
            9'h16B: return 2;
            9'h174: return 3;
            9'h01D: return 4;
            9'h01B: return 5;
            9'h01C: return 6;
            9'h023: return 7;
            9'h05A: return 8;
            9'h076: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 32'(cmdCount), 32'(expQ.size()));
        checkOutput({tag, "_valid"}, 32'(cmdValid), (expQ.size() != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_data"}, 32'(cmdData), (expQ.size() != 0) ? 32'(expQ[0]) : 32'd0);
        checkOutput({tag, "_held"}, 32'(keyHeld), 32'(heldModel));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(ovfModel));
    endtask

    // Strobe one code for lowCycles cycles; optionally pop during the FIFO write cycle.
    task automatic applyStimulus(input logic [9:0] code, input int lowCycles, input bit popDuring);
        int idx;
        ps2Code   = code;
        ps2ReadyN = 1'b0;
        repeat (lowCycles) @(posedge clk);
        #1;
        ps2ReadyN = 1'b1;
        if (popDuring) begin
            if (expQ.size() != 0) begin
                checkOutput("popDuringHead", 32'(cmdData), 32'(expQ[0]));
                void'(expQ.pop_front());
            end
            cmdPop = 1'b1;
        end
        if (lowCycles == 1) begin
            @(posedge clk);
            #1;
        end
        cmdPop = 1'b0;
        if (lowCycles > 1) begin
            @(posedge clk);
            #1;
        end
        idx = lookupKey(code);
        if (idx >= 0) begin
            if (!code[8]) begin
                if (!heldModel[idx]) begin
                    if (expQ.size() < 8) expQ.push_back(3'(cmdOf[idx]));
                    else ovfModel = 1'b1;
                end
                heldModel[idx] = 1'b1;
            end else begin
                heldModel[idx] = 1'b0;
            end
        end
    endtask

    task automatic popOne(input string tag);
        logic [2:0] expHead;
        if (expQ.size() != 0) begin
            expHead = expQ.pop_front();
            checkOutput({tag, "_head"}, 32'(cmdData), 32'(expHead));
        end else begin
            checkOutput({tag, "_emptyData"}, 32'(cmdData), 32'd0);
        end
        cmdPop = 1'b1;
        @(posedge clk);
        #1;
        cmdPop = 1'b0;
        checkOutput({tag, "_count"}, 32'(cmdCount), 32'(expQ.size()));
    endtask

    initial begin
        rst       = 1'b1;
        ps2Code   = '0;
        ps2ReadyN = 1'b1;
        cmdPop    = 1'b0;
        ovfClr    = 1'b0;
        heldModel = '0;
        ovfModel  = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkState("reset");
        rst = 1'b0;

        // Typematic makes of W then its break; repeat instance keeps every make.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'h01D, 1, 1'b0);
            checkOutput("typematicHeld", 32'(keyHeld[4]), 32'd1);
        end
        checkState("typematic");
        checkOutput("repeatCount", 32'(cmdCountRep), 32'd3);
        applyStimulus(10'h11D, 1, 1'b0);
        checkState("typematicBreak");
        for (int i = 0; i < 3; i++) begin
            checkOutput("repeatHead", 32'(cmdDataRep), 32'd1);
            popOne("typematicPop");
        end
        checkOutput("repeatEmpty", 32'(cmdValidRep), 32'd0);

        // Extended up-arrow make then break.
        applyStimulus(10'h275, 1, 1'b0);
        checkState("arrowUp");
        applyStimulus(10'h375, 1, 1'b0);
        checkState("arrowUpBreak");
        popOne("arrowUpPop");
        checkState("arrowUpDrained");

        // Nine distinct makes into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(fillKeys[i], 1, 1'b0);
        end
        checkState("fill");
        ovfClr = 1'b1;
        @(posedge clk);
        #1;
        ovfClr   = 1'b0;
        ovfModel = 1'b0;
        checkState("ovfClear");

        // Full FIFO: push ESC with a same-cycle pop.
        applyStimulus(10'h176, 1, 1'b0);
        applyStimulus(10'h076, 1, 1'b1);
        checkState("fullPushPop");
        for (int i = 0; i < 8; i++) begin
            popOne("drain");
        end
        checkState("drained");

        // Long strobe, unmapped code, pop on empty.
        applyStimulus(10'h15A, 1, 1'b0);
        applyStimulus(10'h05A, 5, 1'b0);
        checkState("longStrobe");
        applyStimulus(10'h21C, 1, 1'b0);
        checkState("unmapped");
        popOne("enterPop");
        popOne("emptyPop");
        checkState("emptyPopState");
        applyStimulus(10'h275, 1, 1'b0);
        checkState("afterEmptyPop");

        // Reset with three entries queued and an event in flight.
        applyStimulus(10'h11B, 1, 1'b0);
        applyStimulus(10'h01B, 1, 1'b0);
        applyStimulus(10'h11C, 1, 1'b0);
        applyStimulus(10'h01C, 1, 1'b0);
        applyStimulus(10'h123, 1, 1'b0);
        checkState("preReset");
        ps2Code   = 10'h023;
        ps2ReadyN = 1'b0;
        @(posedge clk);
        #1;
        ps2ReadyN = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        heldModel = '0;
        ovfModel  = 1'b0;
        checkState("midReset");
        repeat (3) @(posedge clk);
        #1;
        checkState("noLatePush");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
